// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: decoder bundle widths,
// bundle bit positions, the exception state encoding and the bubble value.
package id_ex_stage_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   // Decoder bundle widths
   localparam int EXE_W = 4;
   localparam int MEM_W = 3;
   localparam int WB_W  = 2;

   // control_exe bit positions
   localparam int EXE_REG_DST   = 0;
   localparam int EXE_ALU_SRC   = 1;
   localparam int EXE_ALU_OP_LO = 2;
   localparam int EXE_ALU_OP_HI = 3;

   // control_mem bit positions
   localparam int MEM_READ   = 0;
   localparam int MEM_WRITE  = 1;
   localparam int MEM_BRANCH = 2;

   // control_wb bit positions
   localparam int WB_REG_WRITE = 0;
   localparam int WB_MEM2REG   = 1;

   // RUN: normal flow; EXC: an exception is latched and the stage issues bubbles
   typedef enum logic {
      ST_RUN = 1'b0,
      ST_EXC = 1'b1
   } state_t;

   // Everything the EX stage sees from this register
   typedef struct packed {
      logic             valid;
      logic [EXE_W-1:0] exe;
      logic [MEM_W-1:0] mem;
      logic [WB_W-1:0]  wb;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  rs_data;
      logic [XLEN-1:0]  rt_data;
      logic [XLEN-1:0]  imm;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
   } ex_reg_t;

   // A bubble clears valid and all control bits; data is zeroed as well
   localparam ex_reg_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detection and the IF/ID stall request for the ID/EX stage.
module id_ex_hazard
   import id_ex_stage_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             hold,
   input  logic             in_exc,
   input  logic             flush,
   output logic             load_use,
   output logic             stall_id
);

   // A load in EX whose destination feeds the ID instruction forces a one-cycle bubble;
   // a taken branch overrides any stall because the ID instruction is being killed.
   always_comb begin
      load_use = ex_valid && ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt)) && id_valid;
      stall_id = (load_use || hold || in_exc) && !flush;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, flush, downstream hold and
// first-fault exception latching (epc / exc_pending until acknowledged).
module id_ex_stage
   import id_ex_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [EXE_W-1:0] control_exe,
   input  logic [MEM_W-1:0] control_mem,
   input  logic [WB_W-1:0]  control_wb,
   input  logic             control_exception,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs_data,
   input  logic [XLEN-1:0]  id_rt_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             flush,
   input  logic             hold,
   input  logic             exc_ack,
   output logic             ex_valid,
   output logic [EXE_W-1:0] ex_exe,
   output logic [MEM_W-1:0] ex_mem,
   output logic [WB_W-1:0]  ex_wb,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs_data,
   output logic [XLEN-1:0]  ex_rt_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [REG_W-1:0] ex_rs,
   output logic [REG_W-1:0] ex_rt,
   output logic [REG_W-1:0] ex_rd,
   output logic             stall_id,
   output logic             exc_pending,
   output logic [XLEN-1:0]  epc
);

   state_t          state_q, state_d;
   ex_reg_t         ex_q, ex_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic            load_use;

   id_ex_hazard u_hazard (
      .ex_valid    (ex_q.valid),
      .ex_mem_read (ex_q.mem[MEM_READ]),
      .ex_rt       (ex_q.rt),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .hold        (hold),
      .in_exc      (state_q == ST_EXC),
      .flush       (flush),
      .load_use    (load_use),
      .stall_id    (stall_id)
   );

   // Next-state selection: acknowledge always honoured, hold freezes everything else,
   // otherwise flush > exception-pending > new fault > load-use > load > idle bubble.
   always_comb begin
      state_d = state_q;
      ex_d    = ex_q;
      epc_d   = epc_q;

      if ((state_q == ST_EXC) && exc_ack) begin
         state_d = ST_RUN;
      end

      if (!hold) begin
         if (flush) begin
            ex_d = EX_BUBBLE;
         end else if (state_q == ST_EXC) begin
            ex_d = EX_BUBBLE;
         end else if (id_valid && control_exception) begin
            ex_d    = EX_BUBBLE;
            epc_d   = id_pc;
            state_d = ST_EXC;
         end else if (load_use) begin
            ex_d = EX_BUBBLE;
         end else if (id_valid) begin
            ex_d = '{valid:   1'b1,
                     exe:     control_exe,
                     mem:     control_mem,
                     wb:      control_wb,
                     pc:      id_pc,
                     rs_data: id_rs_data,
                     rt_data: id_rt_data,
                     imm:     id_imm,
                     rs:      id_rs,
                     rt:      id_rt,
                     rd:      id_rd};
         end else begin
            ex_d = EX_BUBBLE;
         end
      end
   end

   // State, EX copies and epc; reset clears all of them immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         ex_q    <= EX_BUBBLE;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         epc_q   <= epc_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_exe      = ex_q.exe;
   assign ex_mem      = ex_q.mem;
   assign ex_wb       = ex_q.wb;
   assign ex_pc       = ex_q.pc;
   assign ex_rs_data  = ex_q.rs_data;
   assign ex_rt_data  = ex_q.rt_data;
   assign ex_imm      = ex_q.imm;
   assign ex_rs       = ex_q.rs;
   assign ex_rt       = ex_q.rt;
   assign ex_rd       = ex_q.rd;
   assign exc_pending = (state_q == ST_EXC);
   assign epc         = epc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/exception/flush/hold
// scenarios followed by biased random traffic against a behavioural model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [3:0]  control_exe;
   logic [2:0]  control_mem;
   logic [1:0]  control_wb;
   logic        control_exception;
   logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        flush, hold, exc_ack;

   logic        ex_valid;
   logic [3:0]  ex_exe;
   logic [2:0]  ex_mem;
   logic [1:0]  ex_wb;
   logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        stall_id, exc_pending;
   logic [31:0] epc;

   int checks   = 0;
   int failures = 0;

   // Reference model: what the EX stage should hold and whether a fault is pending
   bit          mValid;
   logic [3:0]  mExe;
   logic [2:0]  mMem;
   logic [1:0]  mWb;
   logic [31:0] mPc, mRsD, mRtD, mImm, mEpc;
   logic [4:0]  mRs, mRt, mRd;
   bit          mFault;

   // Free-running clock
   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .control_exe(control_exe), .control_mem(control_mem), .control_wb(control_wb),
      .control_exception(control_exception),
      .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .flush(flush), .hold(hold), .exc_ack(exc_ack),
      .ex_valid(ex_valid), .ex_exe(ex_exe), .ex_mem(ex_mem), .ex_wb(ex_wb),
      .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .stall_id(stall_id), .exc_pending(exc_pending), .epc(epc)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic bit modelLoadUse();
      return mValid && mMem[0] && (mRt != 5'd0) && ((mRt == id_rs) || (mRt == id_rt)) && id_valid;
   endfunction

   function automatic bit modelStall();
      return (modelLoadUse() || hold || mFault) && !flush;
   endfunction

   task automatic modelBubble();
      mValid = 0; mExe = '0; mMem = '0; mWb = '0;
      mPc = '0; mRsD = '0; mRtD = '0; mImm = '0;
      mRs = '0; mRt = '0; mRd = '0;
   endtask

   task automatic modelReset();
      modelBubble();
      mFault = 0;
      mEpc   = '0;
   endtask

   // One rising edge of the pipeline as the rules describe it
   task automatic modelEdge();
      bit lu;
      bit ackNow;
      lu     = modelLoadUse();
      ackNow = mFault && exc_ack;
      if (hold) begin
         if (ackNow) mFault = 0;
      end else if (flush) begin
         if (ackNow) mFault = 0;
         modelBubble();
      end else if (mFault) begin
         if (exc_ack) mFault = 0;
         modelBubble();
      end else if (id_valid && control_exception) begin
         modelBubble();
         mEpc   = id_pc;
         mFault = 1;
      end else if (lu || !id_valid) begin
         modelBubble();
      end else begin
         mValid = 1; mExe = control_exe; mMem = control_mem; mWb = control_wb;
         mPc = id_pc; mRsD = id_rs_data; mRtD = id_rt_data; mImm = id_imm;
         mRs = id_rs; mRt = id_rt; mRd = id_rd;
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_valid"}, 32'(ex_valid), 32'(mValid));
      checkOutput({tag, "_exe"}, 32'(ex_exe), 32'(mExe));
      checkOutput({tag, "_mem"}, 32'(ex_mem), 32'(mMem));
      checkOutput({tag, "_wb"}, 32'(ex_wb), 32'(mWb));
      checkOutput({tag, "_pc"}, ex_pc, mPc);
      checkOutput({tag, "_rsdata"}, ex_rs_data, mRsD);
      checkOutput({tag, "_rtdata"}, ex_rt_data, mRtD);
      checkOutput({tag, "_imm"}, ex_imm, mImm);
      checkOutput({tag, "_rs"}, 32'(ex_rs), 32'(mRs));
      checkOutput({tag, "_rt"}, 32'(ex_rt), 32'(mRt));
      checkOutput({tag, "_rd"}, 32'(ex_rd), 32'(mRd));
      checkOutput({tag, "_excp"}, 32'(exc_pending), 32'(mFault));
      checkOutput({tag, "_epc"}, epc, mEpc);
   endtask

   task automatic applyStimulus(input bit valid, input bit exc, input logic [31:0] pc,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [3:0] exe, input logic [2:0] mem, input logic [1:0] wb,
                                input bit fl, input bit hd, input bit ack);
      id_valid = valid; control_exception = exc; id_pc = pc;
      id_rs = rs; id_rt = rt; id_rd = rd;
      control_exe = exe; control_mem = mem; control_wb = wb;
      id_rs_data = pc ^ 32'hA5A5_1234;
      id_rt_data = pc + 32'h0101_0101;
      id_imm     = {pc[15:0], pc[31:16]};
      flush = fl; hold = hd; exc_ack = ack;
   endtask

   // Called at a falling edge with inputs applied; checks stall, clocks, checks state
   task automatic runCycle(input string tag);
      #1 checkOutput({tag, "_stall"}, 32'(stall_id), 32'(modelStall()));
      @(posedge clk);
      modelEdge();
      #1 checkAll(tag);
      @(negedge clk);
   endtask

   // Asynchronous reset between clock edges; outputs must clear with no edge
   task automatic resetMidRun(input string tag);
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput({tag, "_valid0"}, 32'(ex_valid), 32'd0);
      checkOutput({tag, "_pc0"}, ex_pc, 32'd0);
      checkOutput({tag, "_mem0"}, 32'(ex_mem), 32'd0);
      checkOutput({tag, "_excp0"}, 32'(exc_pending), 32'd0);
      checkOutput({tag, "_epc0"}, epc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [4:0] regPick [4] = '{5'd0, 5'd8, 5'd9, 5'd10};

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 32'h0, 0, 0, 0, 4'h0, 3'h0, 2'h0, 0, 0, 0);
      modelReset();
      repeat (2) @(negedge clk);
      checkAll("reset_init");
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Load-use: lw $t0 followed by an add reading $t0
      applyStimulus(1, 0, 32'h0040_0000, 9, 8, 0, 4'b0010, 3'b001, 2'b11, 0, 0, 0);
      runCycle("lw_load");
      applyStimulus(1, 0, 32'h0040_0004, 8, 10, 11, 4'b1001, 3'b000, 2'b01, 0, 0, 0);
      #1 checkOutput("lu_stall_lit", 32'(stall_id), 32'd1);
      runCycle("lu_bubble");
      checkOutput("lu_bubble_lit", 32'(ex_valid), 32'd0);
      runCycle("lu_add");
      checkOutput("lu_add_lit", 32'(ex_valid), 32'd1);
      checkOutput("lu_add_pc_lit", ex_pc, 32'h0040_0004);

      // Load into $zero never stalls
      applyStimulus(1, 0, 32'h0040_0008, 9, 0, 0, 4'b0010, 3'b001, 2'b11, 0, 0, 0);
      runCycle("lw0_load");
      applyStimulus(1, 0, 32'h0040_000C, 0, 10, 11, 4'b1001, 3'b000, 2'b01, 0, 0, 0);
      #1 checkOutput("lw0_stall_lit", 32'(stall_id), 32'd0);
      runCycle("lw0_add");
      checkOutput("lw0_add_lit", 32'(ex_valid), 32'd1);

      // Exception latch, second fault ignored, ack, then resume
      applyStimulus(1, 1, 32'h0040_0010, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 0);
      runCycle("exc_latch");
      checkOutput("exc_pend_lit", 32'(exc_pending), 32'd1);
      checkOutput("exc_epc_lit", epc, 32'h0040_0010);
      checkOutput("exc_bubble_lit", 32'(ex_valid), 32'd0);
      applyStimulus(1, 1, 32'h0040_0020, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 0);
      runCycle("exc_second");
      checkOutput("exc_first_wins_lit", epc, 32'h0040_0010);
      applyStimulus(1, 0, 32'h0040_0024, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 0);
      #1 checkOutput("exc_stall_lit", 32'(stall_id), 32'd1);
      runCycle("exc_wait");
      applyStimulus(1, 0, 32'h0040_0024, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 1);
      runCycle("exc_ack");
      checkOutput("exc_ack_clr_lit", 32'(exc_pending), 32'd0);
      checkOutput("exc_ack_bubble_lit", 32'(ex_valid), 32'd0);
      applyStimulus(1, 0, 32'h0040_0024, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 0);
      runCycle("exc_resume");
      checkOutput("exc_resume_lit", 32'(ex_valid), 32'd1);

      // Flush beats a simultaneous exception
      applyStimulus(1, 1, 32'h0040_0030, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 1, 0, 0);
      #1 checkOutput("flush_stall_lit", 32'(stall_id), 32'd0);
      runCycle("flush_exc");
      checkOutput("flush_excp_lit", 32'(exc_pending), 32'd0);
      checkOutput("flush_bubble_lit", 32'(ex_valid), 32'd0);

      // Hold freezes EX for three cycles, then the waiting instruction loads
      applyStimulus(1, 0, 32'h0040_0040, 4, 5, 6, 4'b0101, 3'b010, 2'b00, 0, 0, 0);
      runCycle("hold_pre");
      applyStimulus(1, 0, 32'h0040_0044, 4, 5, 7, 4'b1000, 3'b000, 2'b01, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         runCycle("hold");
         checkOutput("hold_pc_lit", ex_pc, 32'h0040_0040);
      end
      hold = 1'b0;
      runCycle("hold_rel");
      checkOutput("hold_rel_lit", ex_pc, 32'h0040_0044);

      // Reset while in EXC leaves nothing behind
      applyStimulus(1, 1, 32'h0040_0050, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 0);
      runCycle("exc_prerst");
      resetMidRun("rst_exc");
      applyStimulus(1, 0, 32'h0040_0054, 1, 2, 3, 4'b0001, 3'b000, 2'b01, 0, 0, 0);
      runCycle("post_rst");

      // Biased random traffic
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 9) < 8), ($urandom_range(0, 15) == 0), $urandom,
                       regPick[$urandom_range(0, 3)], regPick[$urandom_range(0, 3)],
                       5'($urandom), 4'($urandom), 3'($urandom), 2'($urandom),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 2) == 0));
         runCycle("rand");
         if (n == 300) resetMidRun("rst_rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 id_valid  in  1  decode stage holds a real instruction.
REQ-004 control_exe  in  4  decoder bundle: [0] RegDst, [1] ALUsrc, [3:2] ALUop.
REQ-005 control_mem  in  3  decoder bundle: [0] MemRead, [1] MemWrite, [2] Branch.
REQ-006 control_wb  in  2  decoder bundle: [0] RegWrite, [1] Mem2Reg.
REQ-007 control_exception  in  1  decoder exception flag.
REQ-008 id_pc, id_rs_data, id_rt_data, id_imm  in  32 each  decode-stage PC, operands, sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-010 flush  in  1  branch taken in EX; kill the ID instruction.
REQ-011 hold  in  1  downstream stall; freeze all EX registers.
REQ-012 exc_ack  in  1  exception handler has taken the pending exception.
REQ-013 ex_valid, ex_exe[3:0], ex_mem[2:0], ex_wb[1:0], ex_pc[31:0], ex_rs_data[31:0], ex_rt_data[31:0], ex_imm[31:0], ex_rs[4:0], ex_rt[4:0], ex_rd[4:0]  out  registered EX-stage copies.
REQ-014 stall_id  out  1  combinational; IF/ID must hold its contents this cycle.
REQ-015 exc_pending  out  1  registered; an exception is latched.
REQ-016 epc  out  32  registered; PC of the faulting instruction.

Function
REQ-017 States RUN and EXC; reset enters RUN.
REQ-018 Load-use hazard = ex_valid & ex_mem[0] & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt) & id_valid.
REQ-019 stall_id = (load-use hazard | hold | state==EXC) & ~flush.
REQ-020 Bubble = ex_valid, ex_exe, ex_mem, ex_wb all 0; data fields are don't-care but loaded with 0.
REQ-021 Per-edge priority: hold (state and all outputs unchanged, exc_ack still honoured) > flush (bubble) > state EXC (bubble) > id_valid & control_exception (bubble, latch) > load-use hazard (bubble) > id_valid (load all ID fields, ex_valid=1) > else bubble.
REQ-022 Latch: epc <= id_pc, exc_pending <= 1, state RUN->EXC, same edge.
REQ-023 In EXC, exc_ack=1 clears exc_pending and returns to RUN on that edge; the next instruction loads no earlier than the following edge.
REQ-024 exc_ack in RUN ignored; a new exception in EXC is ignored (first fault wins, epc stable).
REQ-025 Load-use stall inserts exactly one bubble; the held instruction loads on the next edge with no hazard.
REQ-026 flush and control_exception same cycle: flush wins, no exception latched.
REQ-027 Latency from ID to EX outputs exactly one cycle; no combinational path from inputs to any ex_* output.

Reset
REQ-028 rst_n low immediately forces: state RUN, all ex_* 0, exc_pending 0, epc 0.
REQ-029 rst_n deassertion mid-stall or in EXC leaves no residual state; first edge after release obeys REQ-021.

Structure
REQ-030 Shared package holds bundle widths (4/3/2), bundle bit indices, state encoding, bubble constant.
REQ-031 One sub-module, id_ex_hazard: pure combinational load-use detect and stall_id generation.

Verification
REQ-032 Reset: rst_n=0 mid-run -> all outputs 0 without a clock edge; state RUN.
REQ-033 lw $t0 (rt=8) in EX, ID add rs=8 -> stall_id=1, next edge bubble, following edge add loads, ex_valid=1.
REQ-034 Same lw with rt=0 and ID rs=0 -> no stall; add loads next edge.
REQ-035 ID control_exception=1, id_pc=0x0040_0010 -> next edge exc_pending=1, epc=0x0040_0010, bubble; stays bubbled until exc_ack, clears on ack edge.
REQ-036 flush=1 with control_exception=1 -> bubble, exc_pending stays 0, stall_id=0.
REQ-037 hold=1 for 3 cycles with valid ID -> ex_* frozen, stall_id=1; hold released -> instruction loads next edge.
